// File: rtl/cache_base_ctrl_if.sv
// cache_base_ctrl_if: processor, flush, memory and datapath control signals of the cache controller
interface cache_base_ctrl_if #(parameter int p_num_lines = 32);
    logic memreq_val, memreq_rdy, memreq_type, memresp_val, memresp_rdy;
    logic flush_val, flush_rdy, flush_done, flush_done_rdy;
    logic mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;
    logic [$clog2(p_num_lines)-1:0] req_idx;
    logic req_reg_en, index_mux_sel, index_incr_reg_en, idx_incr_mux_sel;
    logic darray_wen_0, tarray_wen_0, dirty_wen_0, dirty_wdata_0;
    logic darray_wen_1, dirty_wen_1, dirty_wdata_1;
    logic tarray_match, is_dirty_0;
    logic batch_send_istream_val, batch_send_rw, batch_send_addr_sel, batch_send_ostream_rdy;
    logic batch_send_istream_rdy, batch_send_ostream_val;
    logic batch_receive_istream_val, batch_receive_ostream_rdy;
    logic batch_receive_istream_rdy, batch_receive_ostream_val;

    modport slave (
        input  memreq_val, memreq_type, memresp_rdy, flush_val, flush_done_rdy,
               mem_req_rdy, mem_resp_val, req_idx, tarray_match, is_dirty_0,
               batch_send_istream_rdy, batch_send_ostream_val,
               batch_receive_istream_rdy, batch_receive_ostream_val,
        output memreq_rdy, memresp_val, flush_rdy, flush_done, mem_req_val, mem_resp_rdy,
               req_reg_en, index_mux_sel, index_incr_reg_en, idx_incr_mux_sel,
               darray_wen_0, tarray_wen_0, dirty_wen_0, dirty_wdata_0,
               darray_wen_1, dirty_wen_1, dirty_wdata_1,
               batch_send_istream_val, batch_send_rw, batch_send_addr_sel, batch_send_ostream_rdy,
               batch_receive_istream_val, batch_receive_ostream_rdy
    );

    modport master (
        output memreq_val, memreq_type, memresp_rdy, flush_val, flush_done_rdy,
               mem_req_rdy, mem_resp_val, req_idx, tarray_match, is_dirty_0,
               batch_send_istream_rdy, batch_send_ostream_val,
               batch_receive_istream_rdy, batch_receive_ostream_val,
        input  memreq_rdy, memresp_val, flush_rdy, flush_done, mem_req_val, mem_resp_rdy,
               req_reg_en, index_mux_sel, index_incr_reg_en, idx_incr_mux_sel,
               darray_wen_0, tarray_wen_0, dirty_wen_0, dirty_wdata_0,
               darray_wen_1, dirty_wen_1, dirty_wdata_1,
               batch_send_istream_val, batch_send_rw, batch_send_addr_sel, batch_send_ostream_rdy,
               batch_receive_istream_val, batch_receive_ostream_rdy
    );
endinterface

// File: rtl/cache_base_ctrl.sv
// cache_base_ctrl: FSM for a direct-mapped write-back cache: tag check, hit access, eviction, refill and flush
module cache_base_ctrl #(
    parameter int p_num_lines = 32
) (
    input logic clk,
    input logic reset,
    cache_base_ctrl_if.slave bus
);
    localparam int c_idx_w = $clog2(p_num_lines);

    typedef enum logic [3:0] {
        S_IDLE, S_TAG_CHECK, S_EVICT_REQ, S_EVICT_WAIT, S_REFILL_REQ, S_REFILL_WAIT,
        S_RESP, S_FLUSH_CHECK, S_FLUSH_CLEAN, S_FLUSH_NEXT, S_FLUSH_DONE
    } state_e;

    state_e state_q, state_d;
    logic [p_num_lines-1:0] valid_q, valid_d;
    logic [c_idx_w-1:0] flush_cnt_q, flush_cnt_d;
    logic flushing_q, flushing_d;
    logic cur_valid, hit, last_line;

    // while flushing, the line under test is the flush counter rather than the request index
    assign cur_valid = valid_q[flushing_q ? flush_cnt_q : bus.req_idx];
    assign hit = cur_valid & bus.tarray_match;
    assign last_line = flush_cnt_q == c_idx_w'(p_num_lines - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            flush_cnt_q <= '0;
            flushing_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            flush_cnt_q <= flush_cnt_d;
            flushing_q <= flushing_d;
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        flush_cnt_d = flush_cnt_q;
        flushing_d = flushing_q;
        case (state_q)
            S_IDLE: begin
                if (bus.memreq_val) state_d = S_TAG_CHECK;
                else if (bus.flush_val) begin
                    state_d = S_FLUSH_CHECK;
                    flush_cnt_d = '0;
                    flushing_d = 1'b1;
                end
            end
            S_TAG_CHECK: state_d = hit ? S_RESP : (cur_valid & bus.is_dirty_0) ? S_EVICT_REQ : S_REFILL_REQ;
            S_EVICT_REQ: state_d = bus.batch_send_istream_rdy ? S_EVICT_WAIT : S_EVICT_REQ;
            S_EVICT_WAIT: if (bus.batch_receive_ostream_val) state_d = flushing_q ? S_FLUSH_CLEAN : S_REFILL_REQ;
            S_REFILL_REQ: state_d = bus.batch_send_istream_rdy ? S_REFILL_WAIT : S_REFILL_REQ;
            S_REFILL_WAIT: begin
                if (bus.batch_receive_ostream_val) begin
                    valid_d[bus.req_idx] = 1'b1;
                    state_d = S_TAG_CHECK;
                end
            end
            S_RESP: state_d = bus.memresp_rdy ? S_IDLE : S_RESP;
            S_FLUSH_CHECK: state_d = (cur_valid & bus.is_dirty_0) ? S_EVICT_REQ : S_FLUSH_NEXT;
            S_FLUSH_CLEAN: state_d = S_FLUSH_NEXT;
            S_FLUSH_NEXT: begin
                state_d = last_line ? S_FLUSH_DONE : S_FLUSH_CHECK;
                flush_cnt_d = last_line ? flush_cnt_q : flush_cnt_q + c_idx_w'(1);
            end
            S_FLUSH_DONE: begin
                if (bus.flush_done_rdy) begin
                    state_d = S_IDLE;
                    flushing_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.memreq_rdy = 1'b0;
        bus.memresp_val = 1'b0;
        bus.flush_rdy = 1'b0;
        bus.flush_done = 1'b0;
        bus.req_reg_en = 1'b0;
        bus.index_incr_reg_en = 1'b0;
        bus.darray_wen_0 = 1'b0;
        bus.tarray_wen_0 = 1'b0;
        bus.dirty_wen_0 = 1'b0;
        bus.dirty_wdata_0 = 1'b0;
        bus.darray_wen_1 = 1'b0;
        bus.dirty_wen_1 = 1'b0;
        bus.dirty_wdata_1 = 1'b0;
        bus.batch_send_istream_val = 1'b0;
        bus.batch_send_rw = 1'b0;
        bus.batch_send_addr_sel = 1'b0;
        bus.batch_receive_ostream_rdy = 1'b0;
        bus.batch_send_ostream_rdy = bus.mem_req_rdy & ~reset;
        bus.batch_receive_istream_val = bus.mem_resp_val & ~reset;
        bus.mem_req_val = bus.batch_send_ostream_val & ~reset;
        bus.mem_resp_rdy = bus.batch_receive_istream_rdy & ~reset;
        // flushing is only ever set in flush and shared eviction states
        bus.index_mux_sel = flushing_q & ~reset;
        bus.idx_incr_mux_sel = flushing_q & (flush_cnt_q != '0) & ~reset;
        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    bus.memreq_rdy = 1'b1;
                    bus.flush_rdy = ~bus.memreq_val;
                    bus.req_reg_en = bus.memreq_val;
                end
                S_TAG_CHECK: begin
                    bus.darray_wen_1 = hit & bus.memreq_type;
                    bus.dirty_wen_1 = hit & bus.memreq_type;
                    bus.dirty_wdata_1 = hit & bus.memreq_type;
                end
                S_EVICT_REQ: begin
                    bus.batch_send_istream_val = 1'b1;
                    bus.batch_send_rw = 1'b1;
                    bus.batch_send_addr_sel = 1'b1;
                end
                S_EVICT_WAIT: bus.batch_receive_ostream_rdy = 1'b1;
                S_REFILL_REQ: bus.batch_send_istream_val = 1'b1;
                S_REFILL_WAIT: begin
                    bus.batch_receive_ostream_rdy = 1'b1;
                    bus.darray_wen_0 = bus.batch_receive_ostream_val;
                    bus.tarray_wen_0 = bus.batch_receive_ostream_val;
                    bus.dirty_wen_0 = bus.batch_receive_ostream_val;
                end
                S_RESP: bus.memresp_val = 1'b1;
                S_FLUSH_CLEAN: bus.dirty_wen_0 = 1'b1;
                S_FLUSH_NEXT: bus.index_incr_reg_en = 1'b1;
                S_FLUSH_DONE: bus.flush_done = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_base_ctrl.sv
// tb_cache_base_ctrl: IDLE decode vectors, directed corner sequences and random traffic against a line-state model
module tb_cache_base_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cache_base_ctrl_if bus();
    cache_base_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0, n_bad = 0;

    // reference model: what each line should hold after each transaction
    logic [31:0] r_valid = '0, r_dirty = '0;
    int r_tag [32];

    // datapath stand-in, written only by the controller's enables
    logic [31:0] d_dirty = '0;
    int d_tag [32];
    logic [4:0] fidx_q = '0, cur_idx = '0;
    int cur_tag = 0;
    wire [4:0] fidx = bus.idx_incr_mux_sel ? fidx_q : 5'd0;
    wire [4:0] dp_idx = bus.index_mux_sel ? fidx : cur_idx;
    assign bus.req_idx = cur_idx;
    assign bus.is_dirty_0 = d_dirty[dp_idx];
    assign bus.tarray_match = d_tag[dp_idx] == cur_tag;

    bit s_req_fire, s_flush_rdy, s_flush_fire, s_done_fire, s_memresp_val, s_resp_fire;
    bit p_tag_w, p_d0_w, p_d0_v, p_d1_w, p_d1_v, p_inc, p_recv, hold_resp;
    logic [4:0] p_idx, p_fnext;
    logic [31:0] ev_mask;
    int seq, ev_cnt, rf_cnt, burst_wait;

    typedef struct packed {
        logic [6:0] in;
        logic [6:0] exp;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("pt_mem_req_val", 32'(bus.mem_req_val), 32'(bus.batch_send_ostream_val & ~reset));
        check("pt_mem_resp_rdy", 32'(bus.mem_resp_rdy), 32'(bus.batch_receive_istream_rdy & ~reset));
        check("pt_send_ostream_rdy", 32'(bus.batch_send_ostream_rdy), 32'(bus.mem_req_rdy & ~reset));
        check("pt_recv_istream_val", 32'(bus.batch_receive_istream_val), 32'(bus.mem_resp_val & ~reset));
        s_req_fire = bus.memreq_val & bus.memreq_rdy;
        s_flush_rdy = bus.flush_rdy;
        s_flush_fire = bus.flush_val & bus.flush_rdy;
        s_done_fire = bus.flush_done & bus.flush_done_rdy;
        s_memresp_val = bus.memresp_val;
        s_resp_fire = bus.memresp_val & bus.memresp_rdy;
        if (bus.batch_send_istream_val & bus.batch_send_istream_rdy) begin
            seq = seq * 4 + ((bus.batch_send_addr_sel != bus.batch_send_rw) ? 3 : bus.batch_send_rw ? 2 : 1);
            if (bus.batch_send_rw) begin
                ev_cnt++;
                ev_mask[dp_idx] = 1'b1;
            end else rf_cnt++;
            burst_wait = $urandom_range(1, 4);
        end
        p_recv = bus.batch_receive_ostream_val & bus.batch_receive_ostream_rdy;
        p_idx = dp_idx;
        p_fnext = fidx + 5'd1;
        p_tag_w = bus.tarray_wen_0;
        p_d0_w = bus.dirty_wen_0;
        p_d0_v = bus.dirty_wdata_0;
        p_d1_w = bus.dirty_wen_1;
        p_d1_v = bus.dirty_wdata_1;
        p_inc = bus.index_incr_reg_en;
        @(posedge clk);
        #1;
        if (p_tag_w) d_tag[p_idx] = cur_tag;
        if (p_d0_w) d_dirty[p_idx] = p_d0_v;
        if (p_d1_w) d_dirty[p_idx] = p_d1_v;
        if (p_inc) fidx_q = p_fnext;
        if (p_recv) bus.batch_receive_ostream_val = 1'b0;
        if (burst_wait > 0) begin
            burst_wait--;
            if (burst_wait == 0 && !hold_resp) bus.batch_receive_ostream_val = 1'b1;
        end
        bus.batch_send_istream_rdy = $urandom_range(0, 2) != 0;
        bus.batch_send_ostream_val = 1'($urandom_range(0, 1));
        bus.mem_req_rdy = 1'($urandom_range(0, 1));
        bus.mem_resp_val = 1'($urandom_range(0, 1));
        bus.batch_receive_istream_rdy = 1'($urandom_range(0, 1));
        bus.memresp_rdy = 1'($urandom_range(0, 1));
        bus.flush_done_rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic do_req(input logic [4:0] idx, input int tag, input bit wr, input bit with_flush);
        bit hit;
        int exp_seq, lat, n;
        hit = r_valid[idx] && r_tag[idx] == tag;
        exp_seq = hit ? 0 : (r_valid[idx] && r_dirty[idx]) ? 9 : 1;
        if (!hit) begin
            r_valid[idx] = 1'b1;
            r_tag[idx] = tag;
            r_dirty[idx] = 1'b0;
        end
        if (wr) r_dirty[idx] = 1'b1;
        cur_idx = idx;
        cur_tag = tag;
        bus.memreq_type = wr;
        bus.memreq_val = 1'b1;
        if (with_flush) bus.flush_val = 1'b1;
        seq = 0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_req_fire && n < 50);
        check("req_accept", 32'(s_req_fire), 1);
        if (with_flush) check("flush_rdy_while_req", 32'(s_flush_rdy), 0);
        bus.memreq_val = 1'b0;
        lat = 0;
        n = 0;
        while (!s_resp_fire && n < 2000) begin
            tick();
            n++;
            if (s_memresp_val && lat == 0) lat = n;
        end
        check("resp_done", 32'(s_resp_fire), 1);
        check("send_sequence", 32'(seq), 32'(exp_seq));
        if (hit) check("hit_latency", 32'(lat), 2);
    endtask

    task automatic do_flush();
        logic [31:0] exp_mask;
        int n;
        exp_mask = r_valid & r_dirty;
        r_dirty = '0;
        ev_cnt = 0;
        rf_cnt = 0;
        ev_mask = '0;
        bus.flush_val = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_flush_fire && n < 50);
        check("flush_accept", 32'(s_flush_fire), 1);
        bus.flush_val = 1'b0;
        n = 0;
        while (!s_done_fire && n < 5000) begin
            tick();
            n++;
        end
        check("flush_done", 32'(s_done_fire), 1);
        check("flush_evict_lines", ev_mask, exp_mask);
        check("flush_evict_count", 32'(ev_cnt), 32'($countones(exp_mask)));
        check("flush_no_refill", 32'(rf_cnt), 0);
        check("flush_dirty_clear", d_dirty & r_valid, 0);
    endtask

    initial begin
        int n;
        logic [4:0] ridx;
        for (int i = 0; i < 32; i++) begin
            r_tag[i] = -1;
            d_tag[i] = -1;
        end
        {bus.memreq_val, bus.memreq_type, bus.memresp_rdy, bus.flush_val, bus.flush_done_rdy} = '0;
        {bus.mem_req_rdy, bus.mem_resp_val, bus.batch_send_istream_rdy, bus.batch_send_ostream_val} = '0;
        {bus.batch_receive_istream_rdy, bus.batch_receive_ostream_val} = '0;
        burst_wait = 0;
        hold_resp = 1'b0;
        // in: rst mv fv bsov mrr mrv bris / exp: memreq_rdy flush_rdy req_reg_en mem_req_val mem_resp_rdy bsor briv
        tbl[0] = {7'b0000000, 7'b1100000};
        tbl[1] = {7'b0101010, 7'b1011001};
        tbl[2] = {7'b0010101, 7'b1100110};
        tbl[3] = {7'b0111111, 7'b1011111};
        tbl[4] = {7'b1111111, 7'b0000000};
        tbl[5] = {7'b1000000, 7'b0000000};
        tbl[6] = {7'b0011100, 7'b1101010};
        tbl[7] = {7'b0110001, 7'b1010100};
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #2 check("idle_quiet", 32'({bus.memresp_val, bus.flush_done, bus.batch_send_istream_val}), 0);
        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            {reset, bus.memreq_val, bus.flush_val, bus.batch_send_ostream_val,
             bus.mem_req_rdy, bus.mem_resp_val, bus.batch_receive_istream_rdy} = tbl[i].in;
            #2;
            check($sformatf("idle_vec%0d", i), 32'({bus.memreq_rdy, bus.flush_rdy, bus.req_reg_en,
                  bus.mem_req_val, bus.mem_resp_rdy, bus.batch_send_ostream_rdy,
                  bus.batch_receive_istream_val}), 32'(tbl[i].exp));
            {reset, bus.memreq_val, bus.flush_val} = '0;
            @(posedge clk);
            #1;
        end
        // reset while the refill burst is outstanding
        hold_resp = 1'b1;
        cur_idx = 5'd7;
        cur_tag = 9;
        bus.memreq_type = 1'b0;
        bus.memreq_val = 1'b1;
        seq = 0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_req_fire && n < 50);
        bus.memreq_val = 1'b0;
        n = 0;
        while (seq == 0 && n < 100) begin
            tick();
            n++;
        end
        check("refill_sent", 32'(seq), 1);
        tick();
        check("refill_wait_rdy", 32'(bus.batch_receive_ostream_rdy), 1);
        reset = 1'b1;
        tick();
        check("reset_outputs_low", 32'({bus.memreq_rdy, bus.flush_rdy, bus.batch_receive_ostream_rdy,
              bus.req_reg_en, bus.batch_send_istream_val, bus.index_mux_sel, bus.darray_wen_0,
              bus.tarray_wen_0, bus.dirty_wen_0, bus.memresp_val, bus.flush_done}), 0);
        tick();
        reset = 1'b0;
        hold_resp = 1'b0;
        burst_wait = 0;
        bus.batch_receive_ostream_val = 1'b0;
        r_valid = '0;
        @(negedge clk);
        check("rdy_after_reset", 32'(bus.memreq_rdy), 1);
        @(posedge clk);
        #1;
        do_req(5'd7, 9, 1'b0, 1'b0);
        // directed line-state walk on index 0, then a three-line flush
        do_req(5'd0, 1, 1'b0, 1'b0);
        do_req(5'd0, 1, 1'b0, 1'b0);
        do_req(5'd0, 1, 1'b1, 1'b0);
        check("hit_write_dirty", 32'(d_dirty[0]), 1);
        do_req(5'd0, 1, 1'b0, 1'b0);
        do_req(5'd0, 2, 1'b0, 1'b0);
        do_req(5'd3, 5, 1'b1, 1'b0);
        do_req(5'd31, 6, 1'b1, 1'b0);
        do_req(5'd0, 2, 1'b1, 1'b0);
        do_flush();
        do_req(5'd4, 1, 1'b1, 1'b1);
        do_flush();
        do_req(5'd4, 1, 1'b0, 1'b0);
        for (int i = 0; i < 300 && n_bad <= 20; i++) begin
            ridx = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) do_flush();
            else do_req(ridx, $urandom_range(1, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
        end
        if (bus.flush_val) do_flush();
        check("final_dirty_state", d_dirty & r_valid, r_dirty & r_valid);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
